// File: rtl/fb_pkg.sv
// fb_pkg: shared types, defaults and addressing helper for the pixel frame buffer.
package fb_pkg;
  localparam int FB_WIDTH = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_COLOR_BITS = 3;
  typedef enum logic {FB_FILL, FB_IDLE} fb_state_t;
  function automatic logic [31:0] fb_addr(input logic [31:0] x, input logic [31:0] y, input logic [31:0] width);
    return y * width + x;
  endfunction
endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port synchronous RAM, read-first on address collision.
module fb_ram #(
  parameter int DEPTH = 2,
  parameter int DW = 1,
  parameter int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/frame_buffer_mem.sv
// frame_buffer_mem: (x, y) addressed pixel frame buffer with fill engine, bounds checking and read-valid strobe.
module frame_buffer_mem
  import fb_pkg::*;
#(
  parameter int WIDTH = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int COLOR_BITS = FB_COLOR_BITS,
  parameter int XW = 9,
  parameter int YW = 8,
  parameter logic [COLOR_BITS-1:0] INIT_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [XW-1:0]         wr_x,
  input  logic [YW-1:0]         wr_y,
  input  logic [COLOR_BITS-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [XW-1:0]         rd_x,
  input  logic [YW-1:0]         rd_y,
  output logic [COLOR_BITS-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  fill_start,
  input  logic [COLOR_BITS-1:0] fill_color,
  output logic                  busy,
  output logic                  oob_err
);
  localparam int N = WIDTH * HEIGHT;
  localparam int AW = N > 1 ? $clog2(N) : 1;
  fb_state_t state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [COLOR_BITS-1:0] color, color_n;
  logic [AW-1:0] wr_addr, rd_addr, ram_waddr;
  logic [COLOR_BITS-1:0] ram_wdata, ram_q;
  logic last, port_ok, wr_in, rd_in, wr_ok, rd_ok, ram_we, rd_zero;
  assign busy = state == FB_FILL;
  assign last = cnt == AW'(N - 1);
  // a fill request in IDLE takes precedence over any same-cycle port access
  assign port_ok = !busy && !fill_start;
  assign wr_in = 32'(wr_x) < WIDTH && 32'(wr_y) < HEIGHT;
  assign rd_in = 32'(rd_x) < WIDTH && 32'(rd_y) < HEIGHT;
  assign wr_ok = port_ok && wr_en && wr_in;
  assign rd_ok = port_ok && rd_en && rd_in;
  assign wr_addr = AW'(fb_addr(32'(wr_x), 32'(wr_y), WIDTH));
  assign rd_addr = AW'(fb_addr(32'(rd_x), 32'(rd_y), WIDTH));
  assign ram_we = busy || wr_ok;
  assign ram_waddr = busy ? cnt : wr_addr;
  assign ram_wdata = busy ? color : wr_data;
  always_comb begin
    state_n = busy ? (last ? FB_IDLE : FB_FILL) : (fill_start ? FB_FILL : FB_IDLE);
    cnt_n = busy && !last ? cnt + AW'(1) : '0;
    color_n = !busy && fill_start ? fill_color : color;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FB_FILL;
      cnt <= '0;
      color <= INIT_COLOR;
      rd_valid <= 1'b0;
      oob_err <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      color <= color_n;
      rd_valid <= port_ok && rd_en;
      oob_err <= port_ok && ((wr_en && !wr_in) || (rd_en && !rd_in));
      if (port_ok && rd_en) rd_zero <= !rd_in;
    end
  end
  // the RAM output register only moves on in-bounds reads, so rd_zero masks it after reset or an OOB read
  assign rd_data = rd_zero ? '0 : ram_q;
  fb_ram #(.DEPTH(N), .DW(COLOR_BITS), .AW(AW)) u_ram (
    .clk(clk),
    .we(ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re(rd_ok),
    .raddr(rd_addr),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_frame_buffer_mem.sv
// tb_frame_buffer_mem: directed stimulus with a queue scoreboard for read data and oob pulses.
module tb_frame_buffer_mem;
  localparam int W = 5;
  localparam int H = 10;
  localparam int N = W * H;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0, rd_en = 1'b0, fill_start = 1'b0;
  logic [8:0] wr_x = '0, rd_x = '0;
  logic [7:0] wr_y = '0, rd_y = '0;
  logic [2:0] wr_data = '0, fill_color = '0;
  logic [2:0] rd_data;
  logic rd_valid, busy, oob_err;
  int cyc = 0;
  int pass_cnt = 0;
  int tot_cnt = 0;
  typedef struct {int c; int d;} rd_t;
  rd_t rd_q[$];
  int oob_q[$];
  logic [2:0] img [N];
  frame_buffer_mem #(
    .WIDTH(W), .HEIGHT(H), .COLOR_BITS(3), .XW(9), .YW(8), .INIT_COLOR(3'b010)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
    .fill_start(fill_start), .fill_color(fill_color), .busy(busy), .oob_err(oob_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (rd_valid) begin
      if (rd_q.size() == 0) chk("unexpected rd_valid", 1, 0);
      else begin
        rd_t e;
        e = rd_q.pop_front();
        chk("rd_valid cycle", cyc, e.c);
        chk("rd_data", int'(rd_data), e.d);
      end
    end
    if (oob_err) begin
      if (oob_q.size() == 0) chk("unexpected oob_err", 1, 0);
      else chk("oob_err cycle", cyc, oob_q.pop_front());
    end
  end
  task automatic op(input bit we, input int wx, input int wy, input int wd,
                    input bit re, input int rx, input int ry, input bit fs, input int fc);
    @(negedge clk);
    wr_en = we; wr_x = 9'(wx); wr_y = 8'(wy); wr_data = 3'(wd);
    rd_en = re; rd_x = 9'(rx); rd_y = 8'(ry);
    fill_start = fs; fill_color = 3'(fc);
  endtask
  task automatic exp_rd(input int d);
    rd_t e;
    e.c = cyc + 1;
    e.d = d;
    rd_q.push_back(e);
  endtask
  task automatic rd(input int x, input int y, input int d, input bit oob);
    op(0, 0, 0, 0, 1, x, y, 0, 0);
    exp_rd(d);
    if (oob) oob_q.push_back(cyc + 1);
  endtask
  task automatic nop;
    op(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic paint(input int c);
    for (int i = 0; i < N; i++) img[i] = 3'(c);
  endtask
  task automatic readback;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) rd(x, y, int'(img[y * W + x]), 0);
    nop;
  endtask
  // counts negedges with busy high; hold drives port traffic, and a stray fill request is issued mid-fill
  task automatic busy_len(input string name, input bit hold);
    int n = 0;
    while (busy && n < 200) begin
      n++;
      wr_en = hold; wr_x = 9'd0; wr_y = 8'd0; wr_data = 3'b111;
      rd_en = hold; rd_x = 9'd0; rd_y = 8'd10;
      fill_start = n == 10; fill_color = 3'b100;
      @(negedge clk);
    end
    wr_en = 0; rd_en = 0; fill_start = 0;
    chk(name, n, 50);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", int'(busy), 1);
    chk("reset rd_valid", int'(rd_valid), 0);
    chk("reset oob_err", int'(oob_err), 0);
    chk("reset rd_data", int'(rd_data), 0);
    @(negedge clk);
    rst = 0;
    busy_len("post-reset busy length", 0);
    paint(2);
    readback;
    op(1, 4, 9, 5, 0, 0, 0, 0, 0);
    img[49] = 3'b101;
    rd(4, 9, 5, 0);
    op(1, 2, 3, 7, 1, 2, 3, 0, 0);
    exp_rd(2);
    img[17] = 3'b111;
    rd(2, 3, 7, 0);
    op(1, 5, 0, 7, 0, 0, 0, 0, 0);
    oob_q.push_back(cyc + 1);
    rd(0, 10, 0, 1);
    op(1, 0, 10, 7, 1, 7, 2, 0, 0);
    exp_rd(0);
    oob_q.push_back(cyc + 1);
    rd(1, 0, 2, 0);
    readback;
    op(1, 1, 1, 6, 1, 0, 0, 1, 1);
    @(negedge clk);
    busy_len("fill busy length", 0);
    paint(1);
    readback;
    op(0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    repeat (19) @(negedge clk);
    rst = 1;
    #1;
    chk("mid-fill reset busy", int'(busy), 1);
    chk("mid-fill reset rd_data", int'(rd_data), 0);
    chk("mid-fill reset rd_valid", int'(rd_valid), 0);
    @(negedge clk);
    rst = 0;
    busy_len("refill busy length", 0);
    paint(2);
    readback;
    op(0, 0, 0, 0, 0, 0, 0, 1, 6);
    @(negedge clk);
    busy_len("held-port busy length", 1);
    paint(6);
    readback;
    repeat (3) @(negedge clk);
    chk("rd queue drained", rd_q.size(), 0);
    chk("oob queue drained", oob_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
